// File: rtl/platform_button_pkg.sv
// Shared types and constants for the Avalon-MM button poller.
package platform_button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2
    } poll_state_t;

    localparam int BTN_W = 2;
    localparam int EVT_W = 4;
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/platform_button_debounce.sv
// Single-button debouncer: flips after DEBOUNCE_N consecutive differing samples
// and emits a one-cycle press/release pulse on each flip.
module platform_button_debounce
    import platform_button_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sample_en,
    input  logic i_sample,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_press_next,
    output logic o_release_next
);

    localparam int CNT_W = 4;

    logic [CNT_W-1:0] r_cnt;
    logic             r_state;
    logic             r_press;
    logic             r_release;
    logic             w_differ;
    logic             w_flip;

    assign w_differ = i_sample ^ r_state;
    assign w_flip   = i_sample_en && w_differ && (r_cnt == CNT_W'(DEBOUNCE_N - 1));

    // Exposed a cycle early so the event queue can latch in the same edge as the flip.
    assign o_press_next   = w_flip && !r_state;
    assign o_release_next = w_flip && r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= o_press_next;
            r_release <= o_release_next;
            if (i_sample_en) begin
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_state <= ~r_state;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/platform_button_poller.sv
// Polls a button PIO over Avalon-MM every POLL_DIV cycles, debounces each bit
// and queues a single pending press/release event word.
module platform_button_poller
    import platform_button_pkg::*;
#(
    parameter int POLL_DIV   = 50000,
    parameter int DEBOUNCE_N = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       m_address,
    output logic             m_read,
    input  logic [31:0]      m_readdata,
    output logic [BTN_W-1:0] btn_state,
    output logic [BTN_W-1:0] btn_press,
    output logic [BTN_W-1:0] btn_release,
    output logic             event_valid,
    output logic [EVT_W-1:0] event_data,
    input  logic             event_ready,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    poll_state_t      r_fsm;
    logic             r_m_read;
    logic             r_event_valid;
    logic [EVT_W-1:0] r_event_data;
    logic             r_overflow;

    logic             w_div_last;
    logic             w_capture;
    logic [BTN_W-1:0] w_raw;
    logic [BTN_W-1:0] w_press_next;
    logic [BTN_W-1:0] w_release_next;
    logic             w_any_flip;
    logic             w_ovf_set;
    logic             w_unused_rdata;

    assign w_div_last     = (r_div == DIV_W'(POLL_DIV - 1));
    assign w_capture      = (r_fsm == ST_CAPTURE);
    assign w_raw          = ACTIVE_LOW ? ~m_readdata[BTN_W-1:0] : m_readdata[BTN_W-1:0];
    assign w_unused_rdata = ^m_readdata[31:BTN_W];

    // The divider free-runs; the FSM only watches it, so the poll rate never drifts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm    <= ST_IDLE;
            r_m_read <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_div_last) begin
                        r_fsm    <= ST_READ;
                        r_m_read <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_fsm    <= ST_CAPTURE;
                    r_m_read <= 1'b0;
                end
                ST_CAPTURE: begin
                    r_fsm <= ST_IDLE;
                end
                default: begin
                    r_fsm    <= ST_IDLE;
                    r_m_read <= 1'b0;
                end
            endcase
        end
    end

    assign m_read    = r_m_read;
    assign m_address = PIO_DATA_ADDR;

    generate
        for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn
            platform_button_debounce #(
                .DEBOUNCE_N(DEBOUNCE_N)
            ) u_debounce (
                .clk            (clk),
                .reset_n        (reset_n),
                .i_sample_en    (w_capture),
                .i_sample       (w_raw[gi]),
                .o_state        (btn_state[gi]),
                .o_press        (btn_press[gi]),
                .o_release      (btn_release[gi]),
                .o_press_next   (w_press_next[gi]),
                .o_release_next (w_release_next[gi])
            );
        end
    endgenerate

    assign w_any_flip = (|w_press_next) || (|w_release_next);
    assign w_ovf_set  = w_any_flip && r_event_valid && !event_ready;

    // A new flip replaces the pending word only if that word is being accepted now.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event_valid <= 1'b0;
            r_event_data  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_any_flip && (!r_event_valid || event_ready)) begin
                r_event_valid <= 1'b1;
                r_event_data  <= {w_press_next, w_release_next};
            end else if (r_event_valid && event_ready) begin
                r_event_valid <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign event_valid = r_event_valid;
    assign event_data  = r_event_data;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_platform_button_poller.sv
// Directed, table-driven bench for platform_button_poller with a registered PIO slave model.
module tb_platform_button_poller;

    localparam int POLL_DIV   = 4;
    localparam int DEBOUNCE_N = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata = 32'd0;
    logic [1:0]  btn_state;
    logic [1:0]  btn_press;
    logic [1:0]  btn_release;
    logic        event_valid;
    logic [3:0]  event_data;
    logic        event_ready = 1'b0;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [1:0]  in_port = 2'b11;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_read = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: readdata registered on the read strobe, latency 1.
    always @(posedge clk) begin
        if (m_read && m_address == 2'd0) m_readdata <= {30'd0, in_port};
    end

    platform_button_poller #(
        .POLL_DIV  (POLL_DIV),
        .DEBOUNCE_N(DEBOUNCE_N),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_address   (m_address),
        .m_read      (m_read),
        .m_readdata  (m_readdata),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .event_valid (event_valid),
        .event_data  (event_data),
        .event_ready (event_ready),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    // rmode: 0 = ready low, 1 = ready high, 2 = ready high only in the CAPTURE cycle.
    typedef struct {
        logic [1:0]  in_port;
        int          rmode;
        logic        clr;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic [1:0] inp, input int rmode, input logic clr,
                                input logic [1:0] st, input logic [1:0] pr, input logic [1:0] rl,
                                input logic v, input logic [3:0] d, input logic o);
        vec_t r;
        r.in_port = inp;
        r.rmode   = rmode;
        r.clr     = clr;
        r.exp     = {st, pr, rl, v, d, o};
        return r;
    endfunction

    function automatic logic [11:0] observed();
        return {btn_state, btn_press, btn_release, event_valid, event_data, overflow};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_read(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 12; i++) begin
            if (!ok) begin
                @(negedge clk);
                n++;
                if (m_read) ok = 1'b1;
            end
        end
    endtask

    task automatic do_poll(input vec_t v, input int idx);
        int n;
        bit ok;
        in_port      = v.in_port;
        event_ready  = (v.rmode == 1);
        overflow_clr = v.clr;
        wait_read(n, ok);
        check($sformatf("read_seen%0d", idx), {31'd0, ok}, 32'd1);
        if (ok) begin
            check($sformatf("read_addr%0d", idx), {30'd0, m_address}, 32'd0);
            if (prev_read >= 0) check($sformatf("interval%0d", idx), cyc - prev_read, POLL_DIV);
            else                check($sformatf("first_read%0d", idx), n, POLL_DIV);
            prev_read = cyc;
        end
        @(negedge clk);
        if (v.rmode == 2) event_ready = 1'b1;
        @(negedge clk);
        if (v.rmode == 2) event_ready = 1'b0;
        check($sformatf("poll%0d", idx), {20'd0, observed()}, {20'd0, v.exp});
        $display("poll %0d in=%b rmode=%0d clr=%b obs=%b exp=%b",
                 idx, v.in_port, v.rmode, v.clr, observed(), v.exp);
    endtask

    initial begin
        int n;
        bit ok;
        //             in     rm clr  state  press  rel    v     data     ovf
        vecs[0]  = mk(2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0);
        vecs[1]  = mk(2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0);
        vecs[2]  = mk(2'b11, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0);
        vecs[3]  = mk(2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0);
        vecs[4]  = mk(2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0);
        vecs[5]  = mk(2'b10, 0, 0, 2'b01, 2'b01, 2'b00, 1, 4'b0100, 0);
        vecs[6]  = mk(2'b11, 1, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0100, 0);
        vecs[7]  = mk(2'b11, 1, 0, 2'b01, 2'b00, 2'b00, 0, 4'b0100, 0);
        vecs[8]  = mk(2'b11, 1, 0, 2'b00, 2'b00, 2'b01, 1, 4'b0001, 0);
        vecs[9]  = mk(2'b10, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0001, 0);
        vecs[10] = mk(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0001, 0);
        vecs[11] = mk(2'b10, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0001, 0);
        vecs[12] = mk(2'b10, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0001, 0);
        vecs[13] = mk(2'b10, 1, 0, 2'b01, 2'b01, 2'b00, 1, 4'b0100, 0);
        vecs[14] = mk(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[15] = mk(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[16] = mk(2'b00, 0, 0, 2'b11, 2'b10, 2'b00, 1, 4'b0100, 1);
        vecs[17] = mk(2'b00, 0, 1, 2'b11, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[18] = mk(2'b01, 0, 0, 2'b11, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[19] = mk(2'b01, 0, 0, 2'b11, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[20] = mk(2'b01, 0, 1, 2'b10, 2'b00, 2'b01, 1, 4'b0100, 1);
        vecs[21] = mk(2'b01, 0, 1, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[22] = mk(2'b11, 0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[23] = mk(2'b11, 0, 0, 2'b10, 2'b00, 2'b00, 1, 4'b0100, 0);
        vecs[24] = mk(2'b11, 2, 0, 2'b00, 2'b00, 2'b10, 1, 4'b0010, 0);
        vecs[25] = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0010, 0);
        vecs[26] = mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0010, 0);

        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, observed()}, 32'd0);
        check("reset_m_read", {30'd0, m_address, m_read}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) do_poll(vecs[i], i);

        // Third press-both poll: reset lands in the CAPTURE cycle.
        in_port     = 2'b00;
        event_ready = 1'b0;
        wait_read(n, ok);
        check("rst_poll_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midpoll_reset_outputs", {20'd0, observed()}, 32'd0);
        check("midpoll_reset_m_read", {30'd0, m_address, m_read}, 32'd0);
        $display("reset during capture obs=%b m_read=%b", observed(), m_read);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        prev_read = -1;
        // Debounce counts restart from zero, so one pressed sample cannot flip.
        do_poll(mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0), 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
